btn_cursor_ctrl: RTL and testbench
==================================

# btn_cursor_ctrl

Cursor controller that turns debounced push-button levels into cursor moves on the 800x600 VGA frame. It sits between the per-button debouncers and the pixel renderer. It detects press edges, generates hold-to-repeat events, and round-robin arbitrates the four direction requesters. It applies at most one clamped move per video frame, at the frame boundary, so the cursor never tears mid-frame.

## Interface
Parameters:
- REPEAT_DELAY, 25000000: cycles a direction must be held before the first auto-repeat event.
- REPEAT_RATE, 5000000: cycles between subsequent auto-repeat events. Must be 1..REPEAT_DELAY.
- STEP, 8: coarse move size in pixels.
- X_MAX, 799 / Y_MAX, 599: inclusive coordinate limits.
- X_INIT, 400 / Y_INIT, 300: reset position.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- btn_up, btn_down, btn_left, btn_right  in  1 each  debounced levels, high = pressed.
- btn_center  in  1  debounced level; each press toggles fine mode.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- cur_x  out  10  cursor column, 0..X_MAX.
- cur_y  out  10  cursor row, 0..Y_MAX.
- fine_mode  out  1  1 = step of 1 pixel; 0 = step of STEP.
- busy  out  1  high while state is UPDATE.

## Operation
- Direction index order: up=0, down=1, left=2, right=3.
- Edge detect:
  - prev_q holds the last level of each of the five buttons.
  - Press event = level & ~prev_q.
  - prev_q resets to all-ones, so a button held through reset gives no press event.
- Hold counter, one per direction, width ceil(log2(REPEAT_DELAY)):
  - Cleared while the level is low.
  - Increments while the level is high.
  - On reaching REPEAT_DELAY-1 it emits a repeat event and reloads REPEAT_DELAY-REPEAT_RATE.
  - A button held through reset therefore repeats after REPEAT_DELAY cycles.
- pending[3:0]:
  - A press or repeat event sets its bit.
  - Multiple events before service collapse into one.
  - The granted bit clears in UPDATE. If a new event for the same direction arrives in that same cycle, set wins and the bit stays 1.
- Center: a press event toggles fine_mode on the next edge. No repeat, no arbitration, effective in any state.
- FSM:
  - IDLE: stays while pending==0; goes to ARMED when pending!=0.
  - ARMED: on frame_start, latch grant = first set pending bit searching from rr_ptr upward mod 4, then go to UPDATE.
  - UPDATE: one cycle. Apply the move, clear pending[grant], set rr_ptr = (grant+1) mod 4. Go to ARMED if any other pending bit remains, else IDLE.
  - frame_start is ignored in IDLE and UPDATE.
- Move arithmetic, 11-bit intermediates, step s = fine_mode ? 1 : STEP:
  - up: y = (y < s) ? 0 : y-s.
  - down: y = (y+s > Y_MAX) ? Y_MAX : y+s.
  - left / right: same rules applied to x with X_MAX.
  - fine_mode is sampled in the UPDATE cycle.
- Reset values: cur_x=X_INIT, cur_y=Y_INIT, fine_mode=0, busy=0, pending=0, rr_ptr=0, hold counters=0, state IDLE.
- Reset asserted mid-UPDATE discards the move and restores all reset values on that edge.

## Timing
- Level rise at edge N: event sets pending at edge N+1. FSM reaches ARMED at edge N+2.
- frame_start sampled at edge F in ARMED: state is UPDATE after F, and busy=1 for that cycle.
- cur_x/cur_y hold their new value after edge F+1. Latency from frame_start is 2 edges.
- Throughput: at most one move per frame_start.
- Repeat events fire REPEAT_DELAY cycles after the rise, then every REPEAT_RATE cycles while held.
- All outputs are registered.

## Test plan
Use REPEAT_DELAY=20, REPEAT_RATE=5, STEP=8 unless noted.
1. Reset, then idle 10 cycles -> cur_x=400, cur_y=300, fine_mode=0, busy=0 throughout.
2. btn_right pulse for 3 cycles, then frame_start -> busy=1 for one cycle; cur_x=408 two edges after frame_start; a second frame_start gives no change.
3. Clamping:
   - X_INIT=4, left press + frame_start -> cur_x=0.
   - Y_INIT=596, down press + frame_start -> cur_y=599.
   - Left again at x=0 -> stays 0.
4. Arbitration, rr_ptr=0: up and left pressed in the same cycle, then two frame_starts -> first gives cur_y=292, second gives cur_x=392. Then down and up pressed together with rr_ptr=3 -> up is serviced first.
5. Hold btn_right 33 cycles, with frame_start every 2 cycles -> events at rise+1, +20, +25, +30 -> cur_x=432. Release -> no further moves.
6. Fine mode and reset:
   - Center press -> fine_mode=1; right + frame_start -> cur_x=401.
   - Center press -> fine_mode=0.
   - Assert rst during UPDATE -> cur_x=400, pending=0, state IDLE next cycle.

Source files
------------

// File: rtl/btn_cursor_ctrl.sv
// rtl/btn_cursor_ctrl.sv - push-button cursor controller with hold-to-repeat and frame-aligned moves
//
// Turns debounced button levels into cursor moves on the VGA frame. Press
// edges and hold-to-repeat events latch per-direction requests, a round-robin
// arbiter picks one at each frame_start, and the clamped move is applied in a
// single UPDATE cycle so the cursor never changes mid-frame.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   btn_up/down/left/right  debounced direction levels, high = pressed
//   btn_center   debounced level, each press toggles fine_mode
//   frame_start  one-cycle pulse at start of vertical blank
//   cur_x/cur_y  registered cursor position
//   fine_mode    1 = 1-pixel steps, 0 = STEP-pixel steps
//   busy         high for the UPDATE cycle

module btn_cursor_ctrl #(
   parameter int REPEAT_DELAY = 25000000,
   parameter int REPEAT_RATE  = 5000000,
   parameter int STEP         = 8,
   parameter int X_MAX        = 799,
   parameter int Y_MAX        = 599,
   parameter int X_INIT       = 400,
   parameter int Y_INIT       = 300
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_center,
   input  logic       frame_start,
   output logic [9:0] cur_x,
   output logic [9:0] cur_y,
   output logic       fine_mode,
   output logic       busy
);

   localparam int CW = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
   localparam logic [CW-1:0] CNT_LAST   = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] CNT_RELOAD = CW'(REPEAT_DELAY - REPEAT_RATE);

   typedef enum logic [1:0] {IDLE, ARMED, UPDATE} state_t;

   state_t        state;
   logic [4:0]    level;
   logic [4:0]    prev_q;
   logic [4:0]    press;
   logic [CW-1:0] hold_cnt [4];
   logic [3:0]    rpt;
   logic [3:0]    pending;
   logic [3:0]    clr;
   logic [3:0]    pending_nxt;
   logic [1:0]    rr_ptr;
   logic [1:0]    grant;
   logic [1:0]    pick;
   logic [1:0]    idx;
   logic [10:0]   step;
   logic [10:0]   x_ext;
   logic [10:0]   y_ext;
   logic [9:0]    nx;
   logic [9:0]    ny;

   // Bit order matches the direction index: up=0, down=1, left=2, right=3, center=4.
   assign level = {btn_center, btn_right, btn_left, btn_down, btn_up};
   assign press = level & ~prev_q;

   // Gating with level stops a release coinciding with the terminal count
   // from producing a stray repeat.
   always_comb begin
      rpt = '0;
      for (int i = 0; i < 4; i++) begin
         rpt[i] = level[i] && (hold_cnt[i] == CNT_LAST);
      end
   end

   // A new event for the granted direction in the UPDATE cycle wins over the clear.
   assign clr         = (state == UPDATE) ? (4'b0001 << grant) : 4'b0000;
   assign pending_nxt = (pending & ~clr) | press[3:0] | rpt;

   // Round-robin search: scan downward so the lowest offset from rr_ptr wins.
   always_comb begin
      pick = rr_ptr;
      idx  = rr_ptr;
      for (int k = 3; k >= 0; k--) begin
         idx = rr_ptr + 2'(k);
         if (pending[idx]) begin
            pick = idx;
         end
      end
   end

   // Clamped move; 11-bit intermediates keep the overflow/underflow tests exact.
   always_comb begin
      step  = fine_mode ? 11'd1 : 11'(STEP);
      x_ext = {1'b0, cur_x};
      y_ext = {1'b0, cur_y};
      nx    = cur_x;
      ny    = cur_y;
      case (grant)
         2'd0: ny = (y_ext < step) ? 10'd0 : 10'(y_ext - step);
         2'd1: ny = (y_ext + step > 11'(Y_MAX)) ? 10'(Y_MAX) : 10'(y_ext + step);
         2'd2: nx = (x_ext < step) ? 10'd0 : 10'(x_ext - step);
         default: nx = (x_ext + step > 11'(X_MAX)) ? 10'(X_MAX) : 10'(x_ext + step);
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            hold_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (!level[i]) begin
               hold_cnt[i] <= '0;
            end else if (hold_cnt[i] == CNT_LAST) begin
               hold_cnt[i] <= CNT_RELOAD;
            end else begin
               hold_cnt[i] <= hold_cnt[i] + 1'b1;
            end
         end
      end
   end

   // prev_q resets to ones so a button held through reset is not a press.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q    <= '1;
         fine_mode <= 1'b0;
         pending   <= '0;
      end else begin
         prev_q    <= level;
         fine_mode <= fine_mode ^ press[4];
         pending   <= pending_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         busy   <= 1'b0;
         grant  <= 2'd0;
         rr_ptr <= 2'd0;
         cur_x  <= 10'(X_INIT);
         cur_y  <= 10'(Y_INIT);
      end else begin
         case (state)
            IDLE: begin
               busy <= 1'b0;
               if (pending != 4'b0000) begin
                  state <= ARMED;
               end
            end
            ARMED: begin
               if (frame_start) begin
                  grant <= pick;
                  busy  <= 1'b1;
                  state <= UPDATE;
               end
            end
            UPDATE: begin
               cur_x  <= nx;
               cur_y  <= ny;
               rr_ptr <= grant + 2'd1;
               busy   <= 1'b0;
               state  <= (pending_nxt != 4'b0000) ? ARMED : IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_btn_cursor_ctrl.sv
// tb/tb_btn_cursor_ctrl.sv - scoreboard bench for btn_cursor_ctrl against a behavioural model

module tb_btn_cursor_ctrl;

   localparam int RD  = 20;
   localparam int RR  = 5;
   localparam int STP = 8;
   localparam int XM  = 799;
   localparam int YM  = 599;
   localparam int XI  = 400;
   localparam int YI  = 300;

   localparam logic [4:0] U = 5'b00001;
   localparam logic [4:0] D = 5'b00010;
   localparam logic [4:0] L = 5'b00100;
   localparam logic [4:0] R = 5'b01000;
   localparam logic [4:0] C = 5'b10000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       b_up = 1'b0, b_down = 1'b0, b_left = 1'b0, b_right = 1'b0, b_center = 1'b0;
   logic       fs = 1'b0;
   logic [9:0] cur_x, cur_y;
   logic       fine_mode, busy;

   always #5 clk = ~clk;

   btn_cursor_ctrl #(
      .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .STEP(STP),
      .X_MAX(XM), .Y_MAX(YM), .X_INIT(XI), .Y_INIT(YI)
   ) dut (
      .clk(clk), .rst(rst),
      .btn_up(b_up), .btn_down(b_down), .btn_left(b_left), .btn_right(b_right),
      .btn_center(b_center), .frame_start(fs),
      .cur_x(cur_x), .cur_y(cur_y), .fine_mode(fine_mode), .busy(busy)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: held time in cycles, request set, and a 0/1/2 phase
   // (waiting / armed / applying). Positions are plain integers.
   int         m_held [4] = '{default: 0};
   logic [4:0] m_prev  = '1;
   logic [3:0] m_pend  = '0;
   int         m_state = 0;
   int         m_grant = 0;
   int         m_rr    = 0;
   int         m_x     = XI;
   int         m_y     = YI;
   logic       m_fine  = 1'b0;
   int         exp_q[$];

   task automatic step_model();
      logic [4:0] lv;
      logic [3:0] ev, clr, pn;
      int ns, s;
      lv = {b_center, b_right, b_left, b_down, b_up};
      if (rst) begin
         if (m_state == 2) exp_q.push_back(XI * 1024 + YI);
         for (int d = 0; d < 4; d++) m_held[d] = 0;
         m_prev = '1; m_pend = '0; m_state = 0; m_grant = 0; m_rr = 0;
         m_x = XI; m_y = YI; m_fine = 1'b0;
      end else begin
         ev = '0; clr = '0; ns = m_state;
         for (int d = 0; d < 4; d++) begin
            if (lv[d]) m_held[d]++; else m_held[d] = 0;
            ev[d] = lv[d] && (!m_prev[d] || (m_held[d] >= RD && (m_held[d] - RD) % RR == 0));
         end
         if (m_state == 0) begin
            if (m_pend != 0) ns = 1;
         end else if (m_state == 1) begin
            if (fs) begin
               for (int k = 0; k < 4; k++) begin
                  if (m_pend[(m_rr + k) % 4]) begin
                     m_grant = (m_rr + k) % 4;
                     break;
                  end
               end
               ns = 2;
            end
         end else begin
            s = m_fine ? 1 : STP;
            case (m_grant)
               0: m_y = (m_y - s < 0) ? 0 : m_y - s;
               1: m_y = (m_y + s > YM) ? YM : m_y + s;
               2: m_x = (m_x - s < 0) ? 0 : m_x - s;
               default: m_x = (m_x + s > XM) ? XM : m_x + s;
            endcase
            clr[m_grant] = 1'b1;
            m_rr = (m_grant + 1) % 4;
            exp_q.push_back(m_x * 1024 + m_y);
         end
         pn = (m_pend & ~clr) | ev;
         if (m_state == 2) ns = (pn != 0) ? 1 : 0;
         if (lv[4] && !m_prev[4]) m_fine = !m_fine;
         m_pend = pn; m_state = ns; m_prev = lv;
      end
   endtask

   task automatic cyc(input logic [4:0] btns, input logic f, input logic r);
      @(negedge clk);
      {b_center, b_right, b_left, b_down, b_up} = btns;
      fs  = f;
      rst = r;
      step_model();
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(5'b0, 1'b0, 1'b0);
   endtask

   task automatic hold(input logic [4:0] btns, input int n);
      for (int i = 0; i < n; i++) cyc(btns, (i % 2) == 0, 1'b0);
   endtask

   task automatic frame_move(input logic [4:0] btns);
      cyc(btns, 1'b0, 1'b0);
      idle(2);
      cyc(5'b0, 1'b1, 1'b0);
      idle(3);
   endtask

   // Monitor: busy marks a move; the cursor on the following sample must match
   // the next scoreboard entry, and must not change otherwise except under reset.
   initial begin : monitor
      logic after_busy;
      int lx, ly, e;
      after_busy = 1'b0; lx = XI; ly = YI;
      forever begin
         @(posedge clk);
         #1;
         chk("busy", busy, m_state == 2);
         chk("fine_mode", fine_mode, m_fine);
         if (after_busy) begin
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL sb_underflow: move seen, none expected, cur_x=%0d cur_y=%0d", cur_x, cur_y);
            end else begin
               e = exp_q.pop_front();
               chk("move_x", cur_x, e / 1024);
               chk("move_y", cur_y, e % 1024);
            end
         end else if (rst) begin
            chk("rst_x", cur_x, XI);
            chk("rst_y", cur_y, YI);
         end else begin
            chk("hold_x", cur_x, lx);
            chk("hold_y", cur_y, ly);
         end
         after_busy = busy;
         lx = cur_x; ly = cur_y;
      end
   end

   initial begin : driver
      logic [4:0] lv;
      repeat (3) cyc(5'b0, 1'b0, 1'b1);
      idle(10);
      chk("t1_x", cur_x, 400);
      chk("t1_y", cur_y, 300);
      chk("t1_fine", fine_mode, 0);
      chk("t1_busy", busy, 0);

      // single right press, one move per frame_start
      repeat (3) cyc(R, 1'b0, 1'b0);
      cyc(5'b0, 1'b1, 1'b0);
      cyc(5'b0, 1'b0, 1'b0);
      chk("t2_busy", busy, 1);
      cyc(5'b0, 1'b0, 1'b0);
      chk("t2_busy_drop", busy, 0);
      chk("t2_x", cur_x, 408);
      cyc(5'b0, 1'b1, 1'b0);
      idle(3);
      chk("t2_no_second", cur_x, 408);

      // arbitration: up before left from rr_ptr=0, then up before down from rr_ptr=3
      repeat (2) cyc(U | L, 1'b0, 1'b0);
      idle(2);
      cyc(5'b0, 1'b1, 1'b0);
      idle(3);
      chk("t4_up_first_y", cur_y, 292);
      chk("t4_up_first_x", cur_x, 408);
      cyc(5'b0, 1'b1, 1'b0);
      idle(3);
      chk("t4_left_x", cur_x, 400);
      repeat (2) cyc(U | D, 1'b0, 1'b0);
      idle(2);
      cyc(5'b0, 1'b1, 1'b0);
      idle(3);
      chk("t4_rr3_up_y", cur_y, 284);
      cyc(5'b0, 1'b1, 1'b0);
      idle(3);
      chk("t4_down_y", cur_y, 292);

      // hold-to-repeat: 4 events over 33 held cycles
      hold(R, 33);
      hold(5'b0, 40);
      chk("t5_repeat_x", cur_x, 432);

      // fine mode toggling
      cyc(C, 1'b0, 1'b0);
      idle(2);
      chk("t6_fine_on", fine_mode, 1);
      frame_move(R);
      chk("t6_fine_x", cur_x, 433);
      cyc(C, 1'b0, 1'b0);
      idle(2);
      chk("t6_fine_off", fine_mode, 0);

      // reset during UPDATE discards the move
      cyc(R, 1'b0, 1'b0);
      idle(2);
      cyc(5'b0, 1'b1, 1'b0);
      cyc(5'b0, 1'b0, 1'b1);
      cyc(5'b0, 1'b0, 1'b0);
      chk("t6_rst_x", cur_x, 400);
      chk("t6_rst_busy", busy, 0);
      idle(2);

      // clamping at every edge, starting from an odd x so left clamps mid-step
      cyc(C, 1'b0, 1'b0);
      idle(2);
      frame_move(R);
      chk("t3_fine_x", cur_x, 401);
      cyc(C, 1'b0, 1'b0);
      idle(2);
      hold(L, 450);
      idle(6);
      chk("t3_clamp_left", cur_x, 0);
      hold(D, 400);
      idle(6);
      chk("t3_clamp_down", cur_y, 599);
      hold(R, 700);
      idle(6);
      chk("t3_clamp_right", cur_x, 799);
      hold(U, 500);
      idle(6);
      chk("t3_clamp_up", cur_y, 0);

      // randomized levels, frame pulses and occasional reset
      lv = '0;
      for (int i = 0; i < 3000; i++) begin
         for (int b = 0; b < 5; b++) begin
            if ($urandom_range((b == 4) ? 31 : 7, 0) == 0) lv[b] = ~lv[b];
         end
         cyc(lv, $urandom_range(2, 0) == 0, $urandom_range(499, 0) == 0);
      end
      hold(5'b0, 40);
      idle(2);
      chk("sb_drain", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
